pipe_skid_reg: RTL

//  Handshaked pipeline-stage register for the MIPS datapath; the consuming end of a stage boundary.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pipe_skid_reg.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width and the pipeline-stage
// register state encoding.
package mips_pkg;

  localparam int WORD_W = 32;

  // 2'b11 is never produced; the stage decodes it as EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline-stage register with one skid entry, so that in_ready
// can come straight from a flop without costing a bubble at full rate.
module pipe_skid_reg
  import mips_pkg::*;
#(
  parameter int               WIDTH    = WORD_W,
  parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_r;
  skid_state_e      state_nxt_s;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic in_fire_s;
  logic out_fire_s;
  logic load_main_s;
  logic main_from_skid_s;
  logic load_skid_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // State register; in_ready/out_valid are flopped decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_BUSY: begin
          if (in_fire_s && !out_ready) begin
            state_nxt_s = ST_FULL;
          end else if (out_fire_s && !in_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          if (in_fire_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
      endcase
    end
  end

  // Data-path load enables; a flushed cycle loads nothing so old data is kept.
  always_comb begin
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      load_main_s = 1'b0;
    end else begin
      case (state_r)
        ST_BUSY: begin
          if (in_fire_s && out_fire_s) begin
            load_main_s = 1'b1;
          end else if (in_fire_s) begin
            load_skid_s = 1'b1;
          end else begin
            load_main_s = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            load_main_s = 1'b0;
          end
        end
        default: begin
          if (in_fire_s) begin
            load_main_s = 1'b1;
          end else begin
            load_main_s = 1'b0;
          end
        end
      endcase
    end
  end

  // Main and skid data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= RST_DATA;
      skid_r <= RST_DATA;
    end else begin
      if (load_main_s) begin
        dout_r <= main_from_skid_s ? skid_r : din;
      end
      if (load_skid_s) begin
        skid_r <= din;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign dout      = dout_r;

endmodule
